// File: rtl/sccb_master.sv
// Native SCCB master for Omnivision camera register access: 3-phase write, or
// 2-phase write followed by 2-phase read, driving registered SIOC/SIOD pins.
module sccb_master #(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int SCCB_FREQ = 100_000,
  parameter int DIVIDER   = CLK_FREQ / (4 * SCCB_FREQ)
) (
  input  logic       i_clk,
  input  logic       i_rstn,
  input  logic       i_start,
  input  logic       i_rw,
  input  logic [7:0] i_id,
  input  logic [7:0] i_addr,
  input  logic [7:0] i_wdata,
  output logic       o_ready,
  output logic       o_done,
  output logic [7:0] o_rdata,
  output logic       o_ack_err,
  output logic       o_sioc,
  output logic       o_siod_o,
  output logic       o_siod_t,
  input  logic       i_siod_i
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] START   = 3'd1;
  localparam logic [2:0] BYTE    = 3'd2;
  localparam logic [2:0] STOP    = 3'd3;
  localparam logic [2:0] BUSFREE = 3'd4;

  localparam int DW = (DIVIDER > 1) ? $clog2(DIVIDER) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIVIDER - 1);

  if (DIVIDER < 1) begin : g_divider_check
    $error("sccb_master: DIVIDER must be at least 1");
  end

  logic [2:0]    state;
  logic [1:0]    q;
  logic [DW-1:0] div_cnt;
  logic [3:0]    bit_cnt;
  logic [1:0]    byte_cnt;
  logic          busy;
  logic          fin;
  logic          rd_phase;
  logic          samp_pend;
  logic          rw_r;
  logic [6:0]    id_r;
  logic [7:0]    addr_r;
  logic [7:0]    wdata_r;
  logic [6:0]    shreg;
  logic [7:0]    tx_byte;
  logic          tick;
  logic          last_byte;
  logic          rx_byte;
  logic          sioc_n;
  logic          siod_o_n;
  logic          siod_t_n;
  logic          id_lsb_unused;

  assign id_lsb_unused = i_id[0];

  assign tick      = busy && (div_cnt == DIV_LAST);
  assign last_byte = (rw_r || rd_phase) ? (byte_cnt == 2'd1) : (byte_cnt == 2'd2);
  assign rx_byte   = rd_phase && (byte_cnt == 2'd1);

  always_comb begin
    tx_byte = {id_r, 1'b0};
    if (rd_phase)               tx_byte = {id_r, 1'b1};
    else if (byte_cnt == 2'd1)  tx_byte = addr_r;
    else if (byte_cnt == 2'd2)  tx_byte = wdata_r;
  end

  always_comb begin
    sioc_n   = 1'b1;
    siod_o_n = 1'b0;
    siod_t_n = 1'b1;
    case (state)
      START: begin
        sioc_n   = (q != 2'd3);
        siod_o_n = ~q[1];
        siod_t_n = 1'b0;
      end
      BYTE: begin
        sioc_n = q[1];
        // 9th slot: slave X bit (released) or master NA=1 after the read byte
        if (bit_cnt == 4'd8) begin
          if (rx_byte) begin
            siod_t_n = 1'b0;
            siod_o_n = 1'b1;
          end
        end else if (!rx_byte) begin
          siod_t_n = 1'b0;
          siod_o_n = tx_byte[3'd7 - bit_cnt[2:0]];
        end
      end
      STOP: begin
        sioc_n   = (q != 2'd0);
        siod_o_n = (q == 2'd3);
        siod_t_n = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_sioc   <= 1'b1;
      o_siod_o <= 1'b0;
      o_siod_t <= 1'b1;
    end else begin
      o_sioc   <= sioc_n;
      o_siod_o <= siod_o_n;
      o_siod_t <= siod_t_n;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state     <= IDLE;
      q         <= '0;
      div_cnt   <= '0;
      bit_cnt   <= '0;
      byte_cnt  <= '0;
      busy      <= 1'b0;
      fin       <= 1'b0;
      rd_phase  <= 1'b0;
      samp_pend <= 1'b0;
      rw_r      <= 1'b0;
      id_r      <= '0;
      addr_r    <= '0;
      wdata_r   <= '0;
      shreg     <= '0;
      o_ready   <= 1'b1;
      o_done    <= 1'b0;
      o_rdata   <= '0;
      o_ack_err <= 1'b0;
    end else begin
      o_done <= 1'b0;
      fin    <= 1'b0;
      if (fin) begin
        o_done  <= 1'b1;
        o_ready <= 1'b1;
      end

      if (o_ready && i_start) begin
        o_ready   <= 1'b0;
        busy      <= 1'b1;
        state     <= START;
        q         <= '0;
        div_cnt   <= '0;
        bit_cnt   <= '0;
        byte_cnt  <= '0;
        rd_phase  <= 1'b0;
        rw_r      <= i_rw;
        id_r      <= i_id[7:1];
        addr_r    <= i_addr;
        wdata_r   <= i_wdata;
        o_ack_err <= 1'b0;
      end

      if (busy) begin
        div_cnt   <= tick ? '0 : div_cnt + 1'b1;
        // Sampling is delayed one clock so it lands on the pin-level q2->q3 edge
        samp_pend <= tick && (q == 2'd2) && (state == BYTE);

        if (samp_pend) begin
          if (bit_cnt == 4'd8) begin
            if (!rx_byte && i_siod_i) o_ack_err <= 1'b1;
          end else if (rx_byte) begin
            shreg <= {shreg[5:0], i_siod_i};
            if (bit_cnt == 4'd7) o_rdata <= {shreg, i_siod_i};
          end
        end

        if (tick) begin
          if (q != 2'd3) begin
            q <= q + 2'd1;
          end else begin
            q <= '0;
            case (state)
              START: begin
                state   <= BYTE;
                bit_cnt <= '0;
              end
              BYTE: begin
                if (bit_cnt == 4'd8) begin
                  bit_cnt <= '0;
                  if (last_byte) state <= STOP;
                  else           byte_cnt <= byte_cnt + 2'd1;
                end else begin
                  bit_cnt <= bit_cnt + 4'd1;
                end
              end
              STOP: state <= BUSFREE;
              BUSFREE: begin
                if (rw_r && !rd_phase) begin
                  rd_phase <= 1'b1;
                  byte_cnt <= '0;
                  state    <= START;
                end else begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  fin   <= 1'b1;
                end
              end
              default: begin
                state <= IDLE;
                busy  <= 1'b0;
                fin   <= 1'b1;
              end
            endcase
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_sccb_master.sv
// Directed bench for sccb_master: bus decoder + slave model feeding a token
// scoreboard, and a completion scoreboard checked at each o_done.
module tb_sccb_master;

  localparam logic [31:0] TOK_START = 32'h2000;
  localparam logic [31:0] TOK_STOP  = 32'h3000;

  typedef struct {
    int         lat;
    logic [7:0] rdata;
    logic       ack;
    logic       chk_rd;
  } done_t;

  logic       clk   = 1'b0;
  logic       rstn  = 1'b0;
  logic       start = 1'b0;
  logic       rw    = 1'b0;
  logic [7:0] id    = 8'h00;
  logic [7:0] addr  = 8'h00;
  logic [7:0] wdata = 8'h00;
  logic       ready, done, ack_err, sioc, siod_o, siod_t, siod_i;
  logic [7:0] rdata;

  logic       slave_drv;
  logic       x_level = 1'b0;
  logic [7:0] rd_val  = 8'h76;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc_now  = 0;
  int acc_cyc  = 0;
  int last_done_cyc = 0;

  logic [31:0] exp_tok[$];
  done_t       exp_done[$];

  assign siod_i = siod_t ? slave_drv : siod_o;

  always #5 clk = ~clk;
  always @(posedge clk) cyc_now++;

  sccb_master #(.CLK_FREQ(400), .SCCB_FREQ(100)) dut (
    .i_clk    (clk),
    .i_rstn   (rstn),
    .i_start  (start),
    .i_rw     (rw),
    .i_id     (id),
    .i_addr   (addr),
    .i_wdata  (wdata),
    .o_ready  (ready),
    .o_done   (done),
    .o_rdata  (rdata),
    .o_ack_err(ack_err),
    .o_sioc   (sioc),
    .o_siod_o (siod_o),
    .o_siod_t (siod_t),
    .i_siod_i (siod_i)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] tok_byte(input logic [7:0] b, input logic x);
    return 32'h1000 | {23'd0, x, b};
  endfunction

  task automatic mon_tok(input logic [31:0] t);
    if (exp_tok.size() == 0) chk("bus_unexpected_token", t, 32'h0);
    else                     chk("bus_token", t, exp_tok.pop_front());
  endtask

  // Bus decoder and slave: acts on SIOC edges observed at the falling clock edge
  logic prev_scl, prev_sda, seg_read, sda;
  logic [7:0] sh;
  int bit_idx, byte_no;
  always @(negedge clk) begin
    sda = siod_i;
    if (!rstn) begin
      prev_scl  = 1'b1;
      prev_sda  = 1'b1;
      bit_idx   = 0;
      byte_no   = 0;
      seg_read  = 1'b0;
      sh        = 8'h00;
      slave_drv = 1'b1;
    end else begin
      if (sioc && prev_scl && prev_sda && !sda) begin
        mon_tok(TOK_START);
        bit_idx  = 0;
        byte_no  = 0;
        seg_read = 1'b0;
      end else if (sioc && prev_scl && !prev_sda && sda) begin
        mon_tok(TOK_STOP);
        bit_idx = 0;
      end else if (sioc && !prev_scl) begin
        if (bit_idx < 8) sh = {sh[6:0], sda};
        bit_idx++;
        if (bit_idx == 9) begin
          mon_tok(tok_byte(sh, sda));
          if (byte_no == 0) seg_read = sh[0];
          byte_no++;
          bit_idx = 0;
        end
      end else if (!sioc && prev_scl) begin
        if (bit_idx == 8)                     slave_drv = x_level;
        else if (seg_read && byte_no == 1)    slave_drv = rd_val[7 - bit_idx];
        else                                  slave_drv = 1'b1;
      end
      prev_scl = sioc;
      prev_sda = sda;
    end
  end

  task automatic drive_cmd(input logic r, input logic [7:0] i, input logic [7:0] a,
                           input logic [7:0] d);
    done_t e;
    rw = r; id = i; addr = a; wdata = d; start = 1'b1;
    exp_tok.push_back(TOK_START);
    exp_tok.push_back(tok_byte({i[7:1], 1'b0}, x_level));
    exp_tok.push_back(tok_byte(a, x_level));
    if (!r) begin
      exp_tok.push_back(tok_byte(d, x_level));
      exp_tok.push_back(TOK_STOP);
    end else begin
      exp_tok.push_back(TOK_STOP);
      exp_tok.push_back(TOK_START);
      exp_tok.push_back(tok_byte({i[7:1], 1'b1}, x_level));
      exp_tok.push_back(tok_byte(rd_val, 1'b1));
      exp_tok.push_back(TOK_STOP);
    end
    e.lat    = r ? 169 : 121;
    e.rdata  = rd_val;
    e.ack    = x_level;
    e.chk_rd = r;
    exp_done.push_back(e);
  endtask

  task automatic accept();
    @(posedge clk); #1;
    acc_cyc = cyc_now;
    chk("accept_ready_low", ready, 1'b0);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    done_t e;
    int    lim;
    logic  seen;
    e    = exp_done.pop_front();
    seen = 1'b0;
    lim  = cyc_now + 400;
    while (!seen && cyc_now < lim) begin
      @(posedge clk); #1;
      if (done) seen = 1'b1;
    end
    chk({tag, "_done_seen"}, seen, 1'b1);
    if (seen) begin
      last_done_cyc = cyc_now;
      chk({tag, "_latency"}, cyc_now - acc_cyc, e.lat);
      chk({tag, "_ready_at_done"}, ready, 1'b1);
      chk({tag, "_ack_err"}, ack_err, e.ack);
      if (e.chk_rd) chk({tag, "_rdata"}, rdata, e.rdata);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion earlier");
    $fatal(1);
  end

  initial begin
    int cnt;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {sioc, siod_t, siod_o, ready, done, ack_err, rdata},
        {1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00});
    rstn = 1'b1;
    repeat (50) @(posedge clk);
    #1;
    chk("idle_outputs", {sioc, siod_t, siod_o, ready, done, ack_err, rdata},
        {1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00});

    // Plain write
    drive_cmd(1'b0, 8'h42, 8'h12, 8'h80);
    accept();
    wait_done("write");
    chk("write_tokens_left", exp_tok.size(), 0);
    @(posedge clk); #1;
    chk("done_pulse_width", done, 1'b0);

    // Read; ID bit0 set on input must be ignored for the write phase
    drive_cmd(1'b1, 8'h43, 8'h0A, 8'h00);
    accept();
    wait_done("read");
    chk("read_tokens_left", exp_tok.size(), 0);

    // X bit pulled high: completes normally, sticky error cleared by next accept
    x_level = 1'b1;
    drive_cmd(1'b0, 8'h60, 8'h3C, 8'hA5);
    accept();
    wait_done("ackerr");
    x_level = 1'b0;
    drive_cmd(1'b0, 8'h42, 8'h01, 8'h02);
    accept();
    chk("ack_err_cleared", ack_err, 1'b0);
    wait_done("after_ackerr");
    chk("ackerr_tokens_left", exp_tok.size(), 0);

    // Start pulse while busy is ignored
    drive_cmd(1'b0, 8'h42, 8'h33, 8'h5A);
    accept();
    repeat (30) @(posedge clk);
    #1;
    id = 8'h60; addr = 8'h01; wdata = 8'hFF; start = 1'b1;
    @(posedge clk); #1;
    chk("busy_ready_low", ready, 1'b0);
    start = 1'b0;
    wait_done("busy");
    chk("busy_tokens_left", exp_tok.size(), 0);

    // Back-to-back: start held through o_done
    drive_cmd(1'b0, 8'h42, 8'h11, 8'h22);
    accept();
    repeat (10) @(posedge clk);
    #1;
    drive_cmd(1'b0, 8'h42, 8'h44, 8'h88);
    wait_done("b2b_first");
    accept();
    chk("b2b_accept_gap", acc_cyc - last_done_cyc, 1);
    wait_done("b2b_second");
    chk("b2b_tokens_left", exp_tok.size(), 0);

    // Reset during the ADDR byte
    drive_cmd(1'b0, 8'h42, 8'h12, 8'h80);
    accept();
    repeat (50) @(posedge clk);
    #1;
    rstn = 1'b0;
    #1;
    chk("midreset_outputs", {sioc, siod_t, siod_o, ready, done, ack_err, rdata},
        {1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00});
    exp_tok.delete();
    exp_done.delete();
    cnt = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done) cnt++;
    end
    rstn = 1'b1;
    repeat (20) begin
      @(posedge clk); #1;
      if (done) cnt++;
    end
    chk("midreset_no_done", cnt, 0);
    drive_cmd(1'b0, 8'h42, 8'h12, 8'h80);
    accept();
    wait_done("post_reset");
    chk("post_reset_tokens_left", exp_tok.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
